serial_subtractor: RTL and testbench

// Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 93 +++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done request bus of the serial subtractor; master issues operands, slave returns the result.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned      CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             d_bit;
  logic             b_next;

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (b_next)
  );

  // busy/done are kept as flops alongside the state so every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      diff_q <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= b_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout_q <= b_next;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors at WIDTH=8, corner sequences, exhaustive WIDTH=4.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[7];

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Counts edges from now until done is seen (bounded), and how many samples had busy high.
  task automatic wait_done8(output int unsigned edges, output int unsigned busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
      if (bus8.done) break;
    end
  endtask

  task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb);
    int unsigned e, bc;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a     = ~av;
    bus8.b     = ~bv;
    check({name, " cleared at accept"}, {bus8.bout, bus8.diff}, 32'd0);
    wait_done8(e, bc);
    check({name, " latency"}, e, W);
    check({name, " busy cycles"}, bc, W);
    check({name, " diff"}, bus8.diff, ed);
    check({name, " bout"}, bus8.bout, eb);
    @(posedge clk); #1;
    check({name, " done one cycle"}, bus8.done, 1'b0);
    check({name, " diff held"}, bus8.diff, ed);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv);
    logic seen;
    logic [3:0] md;
    seen = 1'b0;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = av;
    bus4.b     = bv;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus4.done) begin
        seen = 1'b1;
        break;
      end
    end
    md = av - bv;
    check($sformatf("w4 %0d-%0d", av, bv), {seen, bus4.bout, bus4.diff},
          {1'b1, (av < bv), md});
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned e, bc, done_hits;

    vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bout: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd10,  diff: 8'd251, bout: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd1,   diff: 8'd255, bout: 1'b1};
    vecs[3] = '{a: 8'd255, b: 8'd255, diff: 8'd0,   bout: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd0,   diff: 8'd0,   bout: 1'b0};
    vecs[5] = '{a: 8'd128, b: 8'd200, diff: 8'd184, bout: 1'b1};
    vecs[6] = '{a: 8'd1,   b: 8'd255, diff: 8'd2,   bout: 1'b1};

    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus8.busy, 1'b0);
    check("reset done", bus8.done, 1'b0);
    check("reset diff", bus8.diff, 32'd0);
    check("reset bout", bus8.bout, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout);

    // start held high; operands changed right after acceptance
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd200;
    bus8.b     = 8'd1;
    @(posedge clk); #1;
    check("hold accepted", bus8.busy, 1'b1);
    bus8.a = 8'd85;
    bus8.b = 8'd16;
    wait_done8(e, bc);
    check("hold latency", e, W);
    check("hold diff", bus8.diff, 32'd199);
    check("hold bout", bus8.bout, 1'b0);
    @(posedge clk); #1;
    check("hold not accepted in DONE", bus8.busy, 1'b0);
    @(posedge clk); #1;
    check("hold re-accepted in IDLE", bus8.busy, 1'b1);
    bus8.start = 1'b0;
    wait_done8(e, bc);
    check("hold second latency", e, W);
    check("hold second diff", bus8.diff, 32'd69);
    check("hold second bout", bus8.bout, 1'b0);
    @(posedge clk); #1;

    // reset on the 4th shift edge aborts the operation
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd100;
    bus8.b     = 8'd37;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy", bus8.busy, 1'b0);
    check("abort diff", bus8.diff, 32'd0);
    check("abort bout", bus8.bout, 1'b0);
    done_hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) done_hits++;
      @(posedge clk); #1;
    end
    check("abort no done", done_hits, 32'd0);
    op8("after abort", 8'd20, 8'd7, 8'd13, 1'b0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
